ahb_master_req_ctrl: RTL

Per-master request controller that sits directly upstream of the per-slave arbiters.
- Decodes the master's address phase into a one-hot request vector, one bit per slave arbiter.
- Stalls the master until the target arbiter grants, then tracks burst beats.
- Drops the request after the last beat so the arbiter can re-arbitrate.
- Returns a two-cycle ERROR response for unmapped addresses.

---
 rtl/ahb_master_req_ctrl_if.sv | 29 ++
 rtl/ahb_master_req_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ahb_master_req_ctrl_if.sv
// Bundle between one AHB master's address phase, the per-slave arbiters and
// the request controller that sits between them.
interface ahb_master_req_ctrl_if #(
   parameter int SLAVE_NUM = 4,
   parameter int ADDR_W    = 32,
   parameter int SEL_BITS  = 2
);
   logic [1:0]           m_htrans;
   logic [ADDR_W-1:0]    m_haddr;
   logic [2:0]           m_hburst;
   logic [SLAVE_NUM-1:0] hgrant;
   logic                 slave_hready;
   logic [SLAVE_NUM-1:0] hreq;
   logic [SEL_BITS-1:0]  s_sel;
   logic                 m_hready;
   logic                 m_hresp;

   // Environment side: the master, the arbiters and the selected slave.
   modport master (
      output m_htrans, m_haddr, m_hburst, hgrant, slave_hready,
      input  hreq, s_sel, m_hready, m_hresp
   );

   // Controller side.
   modport slave (
      input  m_htrans, m_haddr, m_hburst, hgrant, slave_hready,
      output hreq, s_sel, m_hready, m_hresp
   );
endinterface

// File: rtl/ahb_master_req_ctrl.sv
// Per-master request controller: decodes the address phase into a one-hot arbiter
// request, stalls until granted, counts burst beats. Optional REQ_TIMEOUT_EN adds a grant-wait timeout.
module ahb_master_req_ctrl #(
   parameter int SLAVE_NUM = 4,
   parameter int ADDR_W    = 32,
   parameter int SEL_BITS  = 2,
   parameter int TIMEOUT   = 16
) (
   input  logic hclk,
   input  logic hreset,
   ahb_master_req_ctrl_if.slave bus
);

   localparam logic [1:0] HT_IDLE   = 2'd0;
   localparam logic [1:0] HT_NONSEQ = 2'd2;
   localparam logic [2:0] HB_INCR   = 3'd1;

   localparam logic [SLAVE_NUM-1:0] REQ_LSB     = {{(SLAVE_NUM-1){1'b0}}, 1'b1};
   localparam logic [SEL_BITS:0]    SLAVE_LIMIT = (SEL_BITS+1)'(SLAVE_NUM);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_BURST,
      ST_ERR
   } state_t;

   state_t               state;
   logic [SLAVE_NUM-1:0] hreq_q;
   logic [SEL_BITS-1:0]  sel_q;
   logic [3:0]           beat_cnt;
   logic [3:0]           beat_limit;
   logic                 incr_burst;
   logic                 err_second;
   logic                 hresp_q;
   logic                 hready_c;

   logic [SEL_BITS-1:0]  addr_idx;
   logic                 addr_mapped;
   logic                 granted;
   logic                 beat_accept;
   logic                 last_beat;
   logic                 burst_end;

   // Fixed bursts stop when the beat counter reaches this value; INCR ignores it.
   function automatic logic [3:0] limit_of(input logic [2:0] hburst);
      case (hburst)
         3'd2, 3'd3: limit_of = 4'd3;
         3'd4, 3'd5: limit_of = 4'd7;
         3'd6, 3'd7: limit_of = 4'd15;
         default:    limit_of = 4'd0;
      endcase
   endfunction

   assign addr_idx    = bus.m_haddr[ADDR_W-1 -: SEL_BITS];
   assign addr_mapped = {1'b0, addr_idx} < SLAVE_LIMIT;
   assign granted     = |(bus.hgrant & hreq_q);
   assign beat_accept = (state == ST_BURST) && bus.slave_hready && bus.m_htrans[1];
   assign last_beat   = beat_accept && !incr_burst && (beat_cnt == beat_limit);
   // A NONSEQ only ends the burst once its own first beat has been taken.
   assign burst_end   = bus.slave_hready &&
                        ((bus.m_htrans == HT_IDLE) ||
                         ((bus.m_htrans == HT_NONSEQ) && (beat_cnt != 4'd0)));

`ifdef REQ_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wait_cnt;
`endif

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state      <= ST_IDLE;
         hreq_q     <= '0;
         sel_q      <= '0;
         beat_cnt   <= '0;
         beat_limit <= '0;
         incr_burst <= 1'b0;
         err_second <= 1'b0;
         hresp_q    <= 1'b0;
`ifdef REQ_TIMEOUT_EN
         wait_cnt   <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.m_htrans == HT_NONSEQ) begin
                  if (addr_mapped) begin
                     state      <= ST_REQ;
                     sel_q      <= addr_idx;
                     hreq_q     <= REQ_LSB << addr_idx;
                     beat_limit <= limit_of(bus.m_hburst);
                     incr_burst <= (bus.m_hburst == HB_INCR);
`ifdef REQ_TIMEOUT_EN
                     wait_cnt   <= '0;
`endif
                  end else begin
                     state      <= ST_ERR;
                     hresp_q    <= 1'b1;
                     err_second <= 1'b0;
                  end
               end
            end
            ST_REQ: begin
               if (granted) begin
                  state    <= ST_BURST;
                  beat_cnt <= '0;
`ifdef REQ_TIMEOUT_EN
               end else if (wait_cnt == WAIT_LAST) begin
                  state      <= ST_ERR;
                  hreq_q     <= '0;
                  hresp_q    <= 1'b1;
                  err_second <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
`endif
               end
            end
            ST_BURST: begin
               if (last_beat || burst_end) begin
                  state  <= ST_IDLE;
                  hreq_q <= '0;
               end else if (beat_accept && (beat_cnt != 4'hF)) begin
                  beat_cnt <= beat_cnt + 4'd1;
               end
            end
            ST_ERR: begin
               if (err_second) begin
                  state      <= ST_IDLE;
                  hresp_q    <= 1'b0;
                  err_second <= 1'b0;
               end else begin
                  err_second <= 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               hreq_q <= '0;
            end
         endcase
      end
   end

   // A NONSEQ seen in IDLE is held off in the same cycle, before any register reacts.
   always_comb begin
      hready_c = 1'b1;
      case (state)
         ST_IDLE:  hready_c = (bus.m_htrans != HT_NONSEQ);
         ST_REQ:   hready_c = 1'b0;
         ST_BURST: hready_c = bus.slave_hready;
         ST_ERR:   hready_c = err_second;
         default:  hready_c = 1'b1;
      endcase
   end

   assign bus.hreq     = hreq_q;
   assign bus.s_sel    = sel_q;
   assign bus.m_hready = hready_c;
   assign bus.m_hresp  = hresp_q;

endmodule
